// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the two-port data memory arbiter: access sizes,
// FSM states and the byte width of each access size.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        SIZE_1B  = 2'd0,
        SIZE_2B  = 2'd1,
        SIZE_4B  = 2'd2,
        SIZE_ILL = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [2:0] BYTES_1B = 3'd1;
    localparam logic [2:0] BYTES_2B = 3'd2;
    localparam logic [2:0] BYTES_4B = 3'd4;

    // Illegal size reports zero bytes; it is rejected separately.
    function automatic logic [2:0] sizeBytes(input logic [1:0] size);
        case (size)
            SIZE_1B: sizeBytes = BYTES_1B;
            SIZE_2B: sizeBytes = BYTES_2B;
            SIZE_4B: sizeBytes = BYTES_4B;
            default: sizeBytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// port that was not granted last. The last-grant state advances on accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic lastGrant_q;

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = lastGrant_q ? 2'b01 : 2'b10;
        end
    end

    // Resetting to port 1 makes port 0 win the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastGrant_q <= 1'b1;
        end else if (advance_i && (grant_o != 2'b00)) begin
            lastGrant_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port load/store arbiter in front of a single data memory: one access
// in flight at a time, IDLE -> ACCESS -> RESP, or IDLE -> RESP on error.
module data_mem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req_valid,
    input  logic        p0_req_write,
    input  logic [1:0]  p0_req_size,
    input  logic        p0_req_signed,
    input  logic [31:0] p0_req_addr,
    input  logic [31:0] p0_req_wdata,
    output logic        p0_req_ready,
    output logic        p0_resp_valid,
    output logic [31:0] p0_resp_rdata,
    output logic        p0_resp_err,
    input  logic        p1_req_valid,
    input  logic        p1_req_write,
    input  logic [1:0]  p1_req_size,
    input  logic        p1_req_signed,
    input  logic [31:0] p1_req_addr,
    input  logic [31:0] p1_req_wdata,
    output logic        p1_req_ready,
    output logic        p1_resp_valid,
    output logic [31:0] p1_resp_rdata,
    output logic        p1_resp_err,
    output logic        write_mem_4B,
    output logic        write_mem_2B,
    output logic        write_mem_1B,
    output logic        read_mem_4B,
    output logic        read_mem_2B,
    output logic        read_mem_1B,
    output logic        extension_mem,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    logic        owner_q, write_q, signed_q, err_q;
    size_e       size_q;
    logic [31:0] addr_q, wdata_q, rdata_q;

    logic [1:0]  grant;
    logic        accept;
    logic        selPort, selWrite, selSigned, reqErr;
    logic [1:0]  selSize;
    logic [31:0] selAddr, selWdata;
    logic [32:0] endAddr;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .req_i     ({p1_req_valid, p0_req_valid}),
        .advance_i (accept),
        .grant_o   (grant)
    );

    assign p0_req_ready = rst && (state_q == IDLE) && grant[0];
    assign p1_req_ready = rst && (state_q == IDLE) && grant[1];
    assign accept       = p0_req_ready || p1_req_ready;

    // Winning request and its legality; the end address is one bit wider so it cannot wrap.
    always_comb begin
        selPort   = grant[1];
        selWrite  = selPort ? p1_req_write  : p0_req_write;
        selSize   = selPort ? p1_req_size   : p0_req_size;
        selSigned = selPort ? p1_req_signed : p0_req_signed;
        selAddr   = selPort ? p1_req_addr   : p0_req_addr;
        selWdata  = selPort ? p1_req_wdata  : p0_req_wdata;
        endAddr   = {1'b0, selAddr} + {30'd0, sizeBytes(selSize)};
        reqErr    = (selSize == SIZE_ILL)
                 || ((selSize == SIZE_2B) && selAddr[0])
                 || ((selSize == SIZE_4B) && (selAddr[1:0] != 2'b00))
                 || (endAddr > 33'(MEM_BYTES));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = reqErr ? RESP : ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q  <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= SIZE_1B;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            owner_q  <= selPort;
            write_q  <= selWrite;
            size_q   <= size_e'(selSize);
            signed_q <= selSigned;
            addr_q   <= selAddr;
            wdata_q  <= selWdata;
            rdata_q  <= '0;
            err_q    <= reqErr;
        end else if (state_q == ACCESS) begin
            rdata_q  <= write_q ? 32'd0 : mem_rdata;
        end
    end

    // Strobes are decoded from the registered state so reset removes them at once.
    always_comb begin
        write_mem_4B  = 1'b0;
        write_mem_2B  = 1'b0;
        write_mem_1B  = 1'b0;
        read_mem_4B   = 1'b0;
        read_mem_2B   = 1'b0;
        read_mem_1B   = 1'b0;
        extension_mem = 1'b0;
        if (state_q == ACCESS) begin
            if (write_q) begin
                write_mem_4B = (size_q == SIZE_4B);
                write_mem_2B = (size_q == SIZE_2B);
                write_mem_1B = (size_q == SIZE_1B);
            end else begin
                read_mem_4B   = (size_q == SIZE_4B);
                read_mem_2B   = (size_q == SIZE_2B);
                read_mem_1B   = (size_q == SIZE_1B);
                extension_mem = signed_q;
            end
        end
    end

    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;

    assign p0_resp_valid = (state_q == RESP) && !owner_q;
    assign p1_resp_valid = (state_q == RESP) &&  owner_q;
    assign p0_resp_rdata = p0_resp_valid ? rdata_q : 32'd0;
    assign p1_resp_rdata = p1_resp_valid ? rdata_q : 32'd0;
    assign p0_resp_err   = p0_resp_valid && err_q;
    assign p1_resp_err   = p1_resp_valid && err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a byte-array memory model serves the
// strobes, and a shadow memory predicts every response at handshake time.
module tb_data_mem_arbiter;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          expCycle;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic        p0_req_valid, p0_req_write, p0_req_signed, p0_req_ready;
    logic [1:0]  p0_req_size;
    logic [31:0] p0_req_addr, p0_req_wdata, p0_resp_rdata;
    logic        p0_resp_valid, p0_resp_err;
    logic        p1_req_valid, p1_req_write, p1_req_signed, p1_req_ready;
    logic [1:0]  p1_req_size;
    logic [31:0] p1_req_addr, p1_req_wdata, p1_resp_rdata;
    logic        p1_resp_valid, p1_resp_err;
    logic        write_mem_4B, write_mem_2B, write_mem_1B;
    logic        read_mem_4B, read_mem_2B, read_mem_1B, extension_mem;
    logic [31:0] mem_address, mem_write_data, mem_rdata;

    logic [7:0] memArr [0:63];
    logic [7:0] refMem [0:63];
    int         memIdx;

    req_t  q0[$], q1[$];
    resp_t sb[$];
    int    grantLog[$];
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;

    logic        pendValid = 1'b0;
    int          pendCycle;
    logic [6:0]  pendVec;
    logic        pendWrite;
    logic [31:0] pendAddr, pendWdata;

    always #5 clk = ~clk;

    data_mem_arbiter #(.MEM_BYTES(64)) dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_write(p0_req_write), .p0_req_size(p0_req_size),
        .p0_req_signed(p0_req_signed), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_req_ready(p0_req_ready), .p0_resp_valid(p0_resp_valid),
        .p0_resp_rdata(p0_resp_rdata), .p0_resp_err(p0_resp_err),
        .p1_req_valid(p1_req_valid), .p1_req_write(p1_req_write), .p1_req_size(p1_req_size),
        .p1_req_signed(p1_req_signed), .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_req_ready(p1_req_ready), .p1_resp_valid(p1_resp_valid),
        .p1_resp_rdata(p1_resp_rdata), .p1_resp_err(p1_resp_err),
        .write_mem_4B(write_mem_4B), .write_mem_2B(write_mem_2B), .write_mem_1B(write_mem_1B),
        .read_mem_4B(read_mem_4B), .read_mem_2B(read_mem_2B), .read_mem_1B(read_mem_1B),
        .extension_mem(extension_mem), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_rdata(mem_rdata)
    );

    // Little-endian memory model: combinational reads, writes at the clock edge.
    always_comb memIdx = int'(mem_address[5:0]);

    always_comb begin
        mem_rdata = 32'd0;
        if (read_mem_4B && memIdx <= 60)
            mem_rdata = {memArr[memIdx+3], memArr[memIdx+2], memArr[memIdx+1], memArr[memIdx]};
        else if (read_mem_2B && memIdx <= 62)
            mem_rdata = {{16{extension_mem & memArr[memIdx+1][7]}}, memArr[memIdx+1], memArr[memIdx]};
        else if (read_mem_1B)
            mem_rdata = {{24{extension_mem & memArr[memIdx][7]}}, memArr[memIdx]};
    end

    always @(posedge clk) begin
        if (write_mem_4B && memIdx <= 60) begin
            memArr[memIdx]   <= mem_write_data[7:0];
            memArr[memIdx+1] <= mem_write_data[15:8];
            memArr[memIdx+2] <= mem_write_data[23:16];
            memArr[memIdx+3] <= mem_write_data[31:24];
        end else if (write_mem_2B && memIdx <= 62) begin
            memArr[memIdx]   <= mem_write_data[7:0];
            memArr[memIdx+1] <= mem_write_data[15:8];
        end else if (write_mem_1B) begin
            memArr[memIdx]   <= mem_write_data[7:0];
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) memArr[i] <= 8'h00;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    function automatic req_t mkReq(input logic write, input logic [1:0] size, input logic sgn,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.write = write; r.size = size; r.sgn = sgn; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    task automatic applyStimulus();
        p0_req_valid = (q0.size() > 0);
        p1_req_valid = (q1.size() > 0);
        if (q0.size() > 0) begin
            p0_req_write = q0[0].write; p0_req_size = q0[0].size; p0_req_signed = q0[0].sgn;
            p0_req_addr  = q0[0].addr;  p0_req_wdata = q0[0].wdata;
        end
        if (q1.size() > 0) begin
            p1_req_write = q1[0].write; p1_req_size = q1[0].size; p1_req_signed = q1[0].sgn;
            p1_req_addr  = q1[0].addr;  p1_req_wdata = q1[0].wdata;
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        applyStimulus();
    end

    // Reference model: predicts the response and the single strobe cycle of an accepted request.
    task automatic doHandshake(input int port, input req_t r);
        int          n, a;
        logic        err;
        logic [31:0] rd;
        resp_t       e;
        n   = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : (r.size == 2'd2) ? 4 : 0;
        err = (r.size == 2'd3) || (r.size == 2'd1 && r.addr[0])
           || (r.size == 2'd2 && r.addr[1:0] != 2'b00) || ({1'b0, r.addr} + 33'(n) > 33'd64);
        rd  = 32'd0;
        if (!err) begin
            a = int'(r.addr[5:0]);
            if (r.write) begin
                for (int i = 0; i < n; i++) refMem[a+i] = r.wdata[8*i +: 8];
                pendVec = (n == 1) ? 7'b0010000 : (n == 2) ? 7'b0100000 : 7'b1000000;
            end else begin
                for (int i = 0; i < n; i++) rd[8*i +: 8] = refMem[a+i];
                if (r.sgn && rd[8*n-1]) for (int i = n; i < 4; i++) rd[8*i +: 8] = 8'hFF;
                pendVec = ((n == 1) ? 7'b0000010 : (n == 2) ? 7'b0000100 : 7'b0001000) | {6'b0, r.sgn};
            end
            pendValid = 1'b1; pendCycle = cyc + 1; pendWrite = r.write;
            pendAddr = r.addr; pendWdata = r.wdata;
        end
        e.port = port; e.rdata = rd; e.err = err; e.expCycle = cyc + (err ? 1 : 2);
        sb.push_back(e);
        grantLog.push_back(port);
    endtask

    task automatic monitorStep();
        logic [6:0]  strobes, expS;
        resp_t       e;
        int          port;
        req_t        r;
        strobes = {write_mem_4B, write_mem_2B, write_mem_1B, read_mem_4B, read_mem_2B, read_mem_1B, extension_mem};
        expS = 7'd0;
        if (pendValid && pendCycle == cyc) begin
            expS = pendVec;
            pendValid = 1'b0;
            checkOutput("memAddr", mem_address, pendAddr);
            if (pendWrite) checkOutput("memWdata", mem_write_data, pendWdata);
        end
        checkOutput("strobes", 32'(strobes), 32'(expS));
        checkOutput("readyOneHot", 32'(p0_req_ready & p1_req_ready), 32'd0);
        if (p0_resp_valid || p1_resp_valid) begin
            checkOutput("respOneHot", 32'(p0_resp_valid & p1_resp_valid), 32'd0);
            port = p1_resp_valid ? 1 : 0;
            if (sb.size() == 0) begin
                checkOutput("respUnexpected", 32'({p1_resp_valid, p0_resp_valid}), 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("respPort", port, e.port);
                checkOutput("respRdata", port ? p1_resp_rdata : p0_resp_rdata, e.rdata);
                checkOutput("respErr", 32'(port ? p1_resp_err : p0_resp_err), 32'(e.err));
                checkOutput("respCycle", cyc, e.expCycle);
                checkOutput("respOther", port ? (p0_resp_rdata | 32'(p0_resp_err))
                                              : (p1_resp_rdata | 32'(p1_resp_err)), 32'd0);
            end
        end else begin
            checkOutput("respIdle", p0_resp_rdata | p1_resp_rdata | {30'd0, p0_resp_err, p1_resp_err}, 32'd0);
            if (sb.size() > 0 && cyc > sb[0].expCycle) begin
                e = sb.pop_front();
                checkOutput("respMissing", 32'({p1_resp_valid, p0_resp_valid}), (e.port == 1) ? 32'd2 : 32'd1);
            end
        end
        if (p0_req_valid && p0_req_ready && q0.size() > 0) begin
            r = q0.pop_front();
            doHandshake(0, r);
        end else if (p1_req_valid && p1_req_ready && q1.size() > 0) begin
            r = q1.pop_front();
            doHandshake(1, r);
        end
    endtask

    initial forever begin
        @(negedge clk);
        monitorStep();
    end

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) checkOutput("drainTimeout", 32'(q0.size() + q1.size() + sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] saved [0:3];
        int         tries;
        p0_req_valid = 1'b0; p0_req_write = 1'b0; p0_req_size = 2'd0; p0_req_signed = 1'b0;
        p0_req_addr = 32'd0; p0_req_wdata = 32'd0;
        p1_req_valid = 1'b0; p1_req_write = 1'b0; p1_req_size = 2'd0; p1_req_signed = 1'b0;
        p1_req_addr = 32'd0; p1_req_wdata = 32'd0;
        for (int i = 0; i < 64; i++) refMem[i] = 8'h00;

        // Basic store then load of the same word; valid is already high during reset.
        q0.push_back(mkReq(1'b1, 2'd2, 1'b0, 32'd8, 32'hDEADBEEF));
        q0.push_back(mkReq(1'b0, 2'd2, 1'b0, 32'd8, 32'd0));
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rstReady", 32'({p1_req_ready, p0_req_ready}), 32'd0);
        checkOutput("rstRespValid", 32'({p1_resp_valid, p0_resp_valid}), 32'd0);
        checkOutput("rstAddr", mem_address, 32'd0);
        checkOutput("rstWdata", mem_write_data, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        waitDrain(100);

        // Sign extension and upper-boundary accesses.
        q0.push_back(mkReq(1'b1, 2'd0, 1'b0, 32'd5,  32'h00000080));
        q0.push_back(mkReq(1'b0, 2'd0, 1'b1, 32'd5,  32'd0));
        q0.push_back(mkReq(1'b0, 2'd0, 1'b0, 32'd5,  32'd0));
        q0.push_back(mkReq(1'b0, 2'd1, 1'b1, 32'd4,  32'd0));
        q0.push_back(mkReq(1'b1, 2'd2, 1'b0, 32'd60, 32'hCAFEF00D));
        q0.push_back(mkReq(1'b0, 2'd0, 1'b0, 32'd63, 32'd0));
        q0.push_back(mkReq(1'b0, 2'd1, 1'b1, 32'd62, 32'd0));
        q1.push_back(mkReq(1'b0, 2'd2, 1'b1, 32'd60, 32'd0));
        waitDrain(200);

        // Erroneous requests: misaligned, illegal size, past the end of memory.
        q1.push_back(mkReq(1'b0, 2'd2, 1'b0, 32'd6,  32'd0));
        q1.push_back(mkReq(1'b0, 2'd1, 1'b0, 32'd3,  32'd0));
        q1.push_back(mkReq(1'b0, 2'd3, 1'b0, 32'd0,  32'd0));
        q1.push_back(mkReq(1'b0, 2'd2, 1'b0, 32'd62, 32'd0));
        q1.push_back(mkReq(1'b1, 2'd2, 1'b0, 32'd62, 32'h12345678));
        q1.push_back(mkReq(1'b0, 2'd1, 1'b0, 32'd63, 32'd0));
        q1.push_back(mkReq(1'b0, 2'd0, 1'b0, 32'd62, 32'd0));
        waitDrain(200);

        // Reset in the ACCESS cycle of a store discards it entirely.
        for (int i = 0; i < 4; i++) saved[i] = refMem[20+i];
        q0.push_back(mkReq(1'b1, 2'd2, 1'b0, 32'd20, 32'h11223344));
        tries = 0;
        while (tries < 20) begin
            @(negedge clk);
            tries++;
            if (write_mem_4B) break;
        end
        checkOutput("rstStoreStrobe", 32'(write_mem_4B), 32'd1);
        #1 rst = 1'b0;
        #1;
        checkOutput("rstStrobesAsync", 32'({write_mem_4B, write_mem_2B, write_mem_1B, read_mem_4B,
                                            read_mem_2B, read_mem_1B, extension_mem}), 32'd0);
        sb.delete();
        pendValid = 1'b0;
        grantLog.delete();
        for (int i = 0; i < 4; i++) refMem[20+i] = saved[i];
        repeat (2) @(negedge clk);
        checkOutput("rstAddrAfter", mem_address, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Both ports contend for every round: grants alternate starting with p0.
        for (int i = 0; i < 6; i++) begin
            q0.push_back(mkReq(1'b1, 2'd2, 1'b0, 32'(32 + 4*i), 32'hA0000000 + 32'(i)));
            q1.push_back(mkReq(1'b0, 2'd2, 1'b0, 32'(32 + 4*i), 32'd0));
        end
        q0.push_back(mkReq(1'b0, 2'd2, 1'b0, 32'd20, 32'd0));
        waitDrain(300);
        checkOutput("grantCount", grantLog.size(), 32'd13);
        for (int i = 0; i < 12 && i < grantLog.size(); i++)
            checkOutput($sformatf("grantOrder%0d", i), grantLog[i], i % 2);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
